line_buffer2uart_fifo: RTL and testbench
========================================

# line_buffer2uart_fifo

Reads completed output lines from the 4-line output line buffer and writes them, one byte per pixel, into the UART TX FIFO for transmission back to the host. It is the transmit-side counterpart of the RX path that fills the line buffer from the RX FIFO. The upstream processing stage signals each finished line with a `line_ready` pulse. The block tracks pending lines, frame position and overruns, and stalls on TX FIFO full.

## Interface
- `PIXELS`, 256: bytes per line; power of two, at least 4.
- `LINES`, 256: lines per frame.
- `DATA_W`, 8: pixel and FIFO data width.
- `ADDR_W`, 8: pixel address width; equals log2(`PIXELS`).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `line_ready` in 1: one-cycle pulse; one more output line is complete in the line buffer.
- `rd_en` in line-buffer terms, out 1: line-buffer read strobe.
- `rd_line` out 2: line-buffer slot to read, equal to `line_counter[1:0]`.
- `rd_addr` out ADDR_W: pixel index within the slot.
- `rd_data` in DATA_W: read data. Valid the cycle after `rd_en`; held stable until the next `rd_en`.
- `tx_fifo_full` in 1: TX FIFO cannot accept a write this cycle.
- `tx_wr` out 1: TX FIFO write strobe, registered.
- `tx_data` out DATA_W: TX FIFO write data, registered; valid when `tx_wr` is high.
- `line_counter` out 9: index of the line currently or next to be sent.
- `busy` out 1: high whenever the state is not S_IDLE.
- `frame_done` out 1: one-cycle pulse, registered.
- `overrun` out 1: sticky; cleared only by `reset`.

## Operation
- **Reset values:** state = S_IDLE; `pixel_cnt`, `pending`, `line_counter`, `tx_data` = 0; `tx_wr`, `frame_done`, `overrun`, `rd_en`, `busy` = 0.
- **`pending` counter (3 bits, range 0..4):**
  - A `line_ready` pulse increments it.
  - Leaving S_IDLE decrements it.
  - If both happen in the same cycle, it is unchanged.
  - If `line_ready` arrives while `pending` = 4, `pending` stays 4 and `overrun` is set to 1.
- **State S_IDLE:** if `pending` > 0, go to S_FETCH with `pixel_cnt` = 0.
- **State S_FETCH:**
  - `rd_en` = 1 and `rd_addr` = `pixel_cnt`; both are decoded from the registered state.
  - Unconditionally go to S_WRITE.
- **State S_WRITE, when `tx_fifo_full` = 1:**
  - Stay in S_WRITE; `tx_wr` is 0 next cycle.
  - `rd_data` is still valid because no new `rd_en` has been issued.
- **State S_WRITE, when `tx_fifo_full` = 0:**
  - Next cycle, `tx_wr` = 1 and `tx_data` = `rd_data`.
  - If `pixel_cnt` < `PIXELS`-1: increment `pixel_cnt` and go to S_FETCH.
  - Otherwise (line end): clear `pixel_cnt` and go to S_IDLE.
- **Line end:**
  - If `line_counter` = `LINES`-1, `line_counter` wraps to 0 and `frame_done` = 1 for one cycle.
  - Otherwise `line_counter` increments.
  - Both take effect on the same edge as the final `tx_wr`.
- **Other rules:**
  - `tx_wr` is never high for two consecutive cycles.
  - The block never writes while `tx_fifo_full` was sampled high.
  - `pixel_cnt` is ADDR_W+1 bits wide internally; there is no arithmetic wrap mid-line.
  - `reset` mid-line aborts the line: the partial line is not resumed and `pending` is lost.

## Timing
- `line_ready` pulse at cycle t with the block idle and `pending` = 0:
  - t+1: `pending` = 1.
  - t+2: S_FETCH; `busy` = 1, `rd_en` = 1, `rd_addr` = 0, `pending` = 0.
  - t+3: S_WRITE.
  - t+4: first `tx_wr` with pixel 0.
- Throughput without stalls: one byte per 2 cycles. Pixel k is written at t+4+2k; the last pixel at t+2+2·`PIXELS`.
- At the last-pixel cycle: `line_counter` has updated, state = S_IDLE, `busy` = 0.
- With `pending` > 0, the next line's S_FETCH follows one cycle later.
- Each stalled cycle in S_WRITE delays all later writes by one cycle.
- `frame_done` coincides with the final `tx_wr` of line `LINES`-1.

## Test plan
- **Single line:** one `line_ready` with `rd_data` = pixel index. Expect 256 `tx_wr` pulses carrying 0..255 in order, spaced 2 cycles apart, with the first at t+4. Afterwards `line_counter` = 1 and `busy` = 0.
- **Backlog:** 3 `line_ready` pulses on consecutive cycles. Expect 3 lines sent from `rd_line` 0, 1, 2, with exactly one idle cycle between lines. Expect `pending` to end at 0, `line_counter` = 3 and `overrun` = 0.
- **FIFO stall:** hold `tx_fifo_full` = 1 for 10 cycles during pixel 17. Expect no `tx_wr` during the stall, then pixel 17 written once with the correct value, and the full line of 256 bytes with no duplicates or drops.
- **Overrun:** 5 `line_ready` pulses while the block is busy. Expect `overrun` = 1 from the 5th pulse onward, `pending` saturated at 4, and exactly 5 lines sent in total (one in progress plus 4 pending).
- **Frame wrap:** with `LINES` = 4, send 4 lines. Expect `frame_done` to pulse once, together with the final `tx_wr`, and `line_counter` to return to 0.
- **Mid-line reset:** assert `reset` at pixel 100 of line 2. Expect all outputs at their reset values immediately. A new `line_ready` then restarts at line 0, pixel 0.

Source files
------------

// File: rtl/line_buffer2uart_fifo.sv
// rtl/line_buffer2uart_fifo.sv - drains completed line-buffer lines into the UART TX FIFO,
// one byte per pixel, tracking pending lines, frame position and overrun.
module line_buffer2uart_fifo #(
   parameter int PIXELS = 256,
   parameter int LINES  = 256,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_ready,
   output logic              rd_en,
   output logic [1:0]        rd_line,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              tx_fifo_full,
   output logic              tx_wr,
   output logic [DATA_W-1:0] tx_data,
   output logic [8:0]        line_counter,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_t;

   localparam logic [ADDR_W:0] LAST_PIX  = (ADDR_W+1)'(PIXELS - 1);
   localparam logic [8:0]      LAST_LINE = 9'(LINES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   pixel_cnt_q, pixel_cnt_d;
   logic [2:0]        pending_q, pending_d;
   logic [8:0]        line_cnt_q, line_cnt_d;
   logic              tx_wr_q, tx_wr_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
   logic              leave_idle;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pixel_cnt_q  <= '0;
         pending_q    <= '0;
         line_cnt_q   <= '0;
         tx_wr_q      <= 1'b0;
         tx_data_q    <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pixel_cnt_q  <= pixel_cnt_d;
         pending_q    <= pending_d;
         line_cnt_q   <= line_cnt_d;
         tx_wr_q      <= tx_wr_d;
         tx_data_q    <= tx_data_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pixel_cnt_d  = pixel_cnt_q;
      line_cnt_d   = line_cnt_q;
      tx_wr_d      = 1'b0;
      tx_data_d    = tx_data_q;
      frame_done_d = 1'b0;
      leave_idle   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pending_q != 3'd0) begin
               state_d     = S_FETCH;
               pixel_cnt_d = '0;
               leave_idle  = 1'b1;
            end
         end
         S_FETCH: state_d = S_WRITE;
         S_WRITE: begin
            // rd_data stays valid across a stall since no new read is issued
            if (!tx_fifo_full) begin
               tx_wr_d   = 1'b1;
               tx_data_d = rd_data;
               if (pixel_cnt_q < LAST_PIX) begin
                  pixel_cnt_d = pixel_cnt_q + 1'b1;
                  state_d     = S_FETCH;
               end else begin
                  pixel_cnt_d = '0;
                  state_d     = S_IDLE;
                  if (line_cnt_q == LAST_LINE) begin
                     line_cnt_d   = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     line_cnt_d = line_cnt_q + 9'd1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (line_ready && !leave_idle) begin
         if (pending_q == 3'd4) overrun_d = 1'b1;
         else                   pending_d = pending_q + 3'd1;
      end else if (!line_ready && leave_idle) begin
         pending_d = pending_q - 3'd1;
      end
   end

   assign rd_en        = (state_q == S_FETCH);
   assign rd_addr      = pixel_cnt_q[ADDR_W-1:0];
   assign rd_line      = line_cnt_q[1:0];
   assign tx_wr        = tx_wr_q;
   assign tx_data      = tx_data_q;
   assign line_counter = line_cnt_q;
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_line_buffer2uart_fifo.sv
// tb/tb_line_buffer2uart_fifo.sv - directed self-checking bench for line_buffer2uart_fifo.
module tb_line_buffer2uart_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       line_ready = 1'b0;
   logic       rd_en;
   logic [1:0] rd_line;
   logic [7:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       tx_fifo_full = 1'b0;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic [8:0] line_counter;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic full_at_edge = 1'b0;
   logic prev_wr = 1'b0;
   int viol = 0;
   int fd_cnt = 0;
   int wr_cyc[$];
   int wr_dat[$];
   int wr_fd[$];
   int fe_line[$];
   int fe_addr[$];

   line_buffer2uart_fifo #(.PIXELS(256), .LINES(4), .DATA_W(8), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .line_ready(line_ready),
      .rd_en(rd_en), .rd_line(rd_line), .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_fifo_full(tx_fifo_full), .tx_wr(tx_wr), .tx_data(tx_data),
      .line_counter(line_counter), .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic int exp_data(input int line, input int addr);
      return (addr + 37 * line) & 255;
   endfunction

   // line-buffer model: data appears the cycle after rd_en
   always @(posedge clk) if (rd_en) rd_data <= 8'(exp_data(int'(rd_line), int'(rd_addr)));

   always @(posedge clk) begin
      cyc = cyc + 1;
      full_at_edge = tx_fifo_full;
   end

   always @(negedge clk) begin
      if (tx_wr) begin
         wr_cyc.push_back(cyc);
         wr_dat.push_back(int'(tx_data));
         wr_fd.push_back(int'(frame_done));
         if (full_at_edge) viol = viol + 1;
         if (prev_wr) viol = viol + 1;
      end
      prev_wr = tx_wr;
      if (frame_done) fd_cnt = fd_cnt + 1;
      if (rd_en) begin
         fe_line.push_back(int'(rd_line));
         fe_addr.push_back(int'(rd_addr));
      end
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      wr_cyc.delete(); wr_dat.delete(); wr_fd.delete();
      fe_line.delete(); fe_addr.delete();
      viol = 0; fd_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic pulse(output int t);
      line_ready = 1'b1;
      t = cyc;
      @(negedge clk); #1;
      line_ready = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int k = 0;
      while (wr_dat.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      chk(tag, wr_dat.size(), n);
   endtask

   task automatic chk_line_data(input string tag, input int first_line, input int nlines);
      int bad = 0;
      for (int k = 0; k < nlines * 256; k++) begin
         if (wr_dat[k] != exp_data((first_line + k / 256) % 4, k % 256)) bad++;
         if (fe_line[k] != (first_line + k / 256) % 4 || fe_addr[k] != k % 256) bad++;
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      int t;
      int bad;

      // reset state
      @(negedge clk); #1;
      chk("reset_outputs", {tx_wr, tx_data, line_counter, busy, rd_en, frame_done, overrun, rd_line, rd_addr}, 0);
      reset = 1'b0;
      clear_logs();
      @(negedge clk); #1;
      chk("idle_after_reset", {busy, rd_en, tx_wr}, 0);

      // single line
      pulse(t);
      chk("not_busy_t+1", busy, 0);
      @(negedge clk); #1;
      chk("fetch_t+2", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 8'd0});
      wait_writes(256, 1000, "single_count");
      chk("single_first_cycle", wr_cyc[0], t + 4);
      chk("single_last_cycle", wr_cyc[255], t + 2 + 2 * 256);
      bad = 0;
      for (int k = 0; k < 256; k++)
         if (wr_dat[k] != k || wr_cyc[k] != t + 4 + 2 * k) bad++;
      chk("single_data_spacing", bad, 0);
      chk("single_lc_at_last", line_counter, 1);
      chk("single_busy_at_last", busy, 0);
      chk("single_viol", viol, 0);

      // backlog of three lines
      do_reset();
      pulse(t); pulse(t); pulse(t);
      wait_writes(768, 2000, "backlog_count");
      chk_line_data("backlog_data", 0, 3);
      chk("backlog_gap1", wr_cyc[256] - wr_cyc[255], 3);
      chk("backlog_gap2", wr_cyc[512] - wr_cyc[511], 3);
      chk("backlog_lc", line_counter, 3);
      chk("backlog_overrun", overrun, 0);
      repeat (10) @(negedge clk);
      #1;
      chk("backlog_no_extra", wr_dat.size(), 768);
      chk("backlog_idle", busy, 0);
      chk("backlog_viol", viol, 0);

      // frame wrap with LINES = 4
      do_reset();
      pulse(t); pulse(t); pulse(t); pulse(t);
      wait_writes(1024, 3000, "frame_count");
      chk("frame_fd_once", fd_cnt, 1);
      chk("frame_fd_on_last_wr", wr_fd[1023], 1);
      chk("frame_lc_wrapped", line_counter, 0);
      chk_line_data("frame_data", 0, 4);

      // FIFO stall during pixel 17
      do_reset();
      pulse(t);
      wait_writes(17, 200, "stall_pre_count");
      @(negedge clk); #1;
      tx_fifo_full = 1'b1;
      repeat (10) begin
         @(negedge clk); #1;
      end
      chk("stall_no_write", wr_dat.size(), 17);
      tx_fifo_full = 1'b0;
      wait_writes(256, 1000, "stall_count");
      chk("stall_p17_cycle", wr_cyc[17], t + 48);
      chk("stall_p17_data", wr_dat[17], 17);
      chk_line_data("stall_data", 0, 1);
      chk("stall_viol", viol, 0);

      // overrun: one line in progress, then five more pulses
      do_reset();
      pulse(t);
      repeat (3) @(negedge clk);
      #1;
      repeat (4) begin
         pulse(t);
         @(negedge clk); #1;
      end
      chk("overrun_before_5th", overrun, 0);
      pulse(t);
      chk("overrun_after_5th", overrun, 1);
      wait_writes(1280, 3000, "overrun_count");
      repeat (20) @(negedge clk);
      #1;
      chk("overrun_exact_5_lines", wr_dat.size(), 1280);
      chk_line_data("overrun_data", 0, 5);
      chk("overrun_sticky", overrun, 1);
      chk("overrun_idle", busy, 0);

      // mid-line reset at pixel 100 of line 2
      do_reset();
      pulse(t); pulse(t); pulse(t);
      wait_writes(613, 2000, "midreset_pre_count");
      chk("midreset_pixel100", wr_dat[612], exp_data(2, 100));
      reset = 1'b1;
      #1;
      chk("midreset_outputs", {tx_wr, tx_data, line_counter, busy, rd_en, frame_done, overrun, rd_line, rd_addr}, 0);
      @(negedge clk); #1;
      reset = 1'b0;
      clear_logs();
      repeat (5) @(negedge clk);
      #1;
      chk("midreset_pending_lost", wr_dat.size() + fe_line.size(), 0);
      pulse(t);
      wait_writes(1, 50, "restart_count");
      chk("restart_fetch", {fe_line[0], fe_addr[0]}, 0);
      chk("restart_cycle", wr_cyc[0], t + 4);
      chk("restart_data", wr_dat[0], 0);
      chk("restart_lc", line_counter, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
